// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the logic unit, the result queue and write-back.
// The producer side (in_*) and consumer side (out_*) are carried together so
// the queue has a single bus port. The queue uses the slave view; the
// surrounding logic uses the master view.
interface alu_result_queue_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_op;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_op, out_flags
    );

    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_data, out_op, out_flags
    );
endinterface

// File: rtl/alu_result_queue.sv
// alu_result_queue: small FIFO between the logic unit and register-file
// write-back. Each entry holds the result, its op select and flags {P,C,S,Z}
// computed at capture. The last popped result is kept in acc_q, and a sticky
// proto_err flags a producer that withdraws or alters a stalled request.
// Optional build macro: PARITY_FLAG_EN (adds the even-parity flag P; P=0
// otherwise).
module alu_result_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_queue_if.slave bus,
    output logic [WIDTH-1:0] acc_q,
    output logic [3:0]       count,
    output logic             proto_err
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [2:0]       op;
        logic [3:0]       flags;   // {P,C,S,Z}
    } entry_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             in_ready_q;
    logic             stall_q;
    logic [WIDTH-1:0] held_data_q;
    logic [2:0]       held_op_q;
    logic             proto_err_q;
    entry_t           mem_q [DEPTH];

    logic   push, pop;
    logic   parity;
    logic   violation;
    entry_t entry_in;
    entry_t head;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = bus.out_valid & bus.out_ready;

`ifdef PARITY_FLAG_EN
    assign parity = ~^bus.in_data;
`else
    assign parity = 1'b0;
`endif

    assign entry_in.data  = bus.in_data;
    assign entry_in.op    = bus.in_op;
    assign entry_in.flags = {parity, (bus.in_op == 3'd7), bus.in_data[WIDTH-1],
                             (bus.in_data == '0)};

    assign head = mem_q[rd_ptr_q];

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = head.data;
    assign bus.out_op    = head.op;
    assign bus.out_flags = head.flags;
    assign count         = count_q;
    assign proto_err     = proto_err_q;

    // A stalled request must be held stable until it is accepted.
    assign violation = stall_q & (~bus.in_valid |
                       (((bus.in_data != held_data_q) | (bus.in_op != held_op_q)) & ~push));

    // Occupancy next state and count from this cycle's push/pop.
    always_comb begin
        // NOTE: defaults first so every path assigns state_d/count_d and no latch is inferred.
        state_d = state_q;
        count_d = count_q + {3'b000, push} - {3'b000, pop};
        case (state_q)
            EMPTY:   if (push) state_d = PARTIAL;
            PARTIAL: begin
                if (push && !pop && (count_q + 4'd1 == DEPTH_C)) state_d = FULL;
                else if (pop && !push && (count_q == 4'd1))      state_d = EMPTY;
            end
            FULL:    if (pop) state_d = PARTIAL;
            default: state_d = EMPTY;
        endcase
    end

    // Control state: occupancy, pointers, registered in_ready, accumulator, protocol monitor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            count_q     <= 4'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_ready_q  <= 1'b0;
            acc_q       <= '0;
            stall_q     <= 1'b0;
            held_data_q <= '0;
            held_op_q   <= 3'd0;
            proto_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            count_q     <= count_d;
            in_ready_q  <= (state_d != FULL);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                acc_q    <= head.data;
            end
            stall_q     <= bus.in_valid & ~in_ready_q;
            held_data_q <= bus.in_data;
            held_op_q   <= bus.in_op;
            if (violation) proto_err_q <= 1'b1;
        end
    end

    // Entry storage; written on push only.
    // NOTE: the array has no reset -- validity is tracked by count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue (WIDTH=8, DEPTH=2). Inputs are driven
// 1 ns after the rising edge and outputs are sampled at that same point, so
// each tick() shows the state produced by one clock edge.
module tb_alu_result_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
`ifdef PARITY_FLAG_EN
    localparam logic P_EN = 1'b1;
`else
    localparam logic P_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] acc_q;
    logic [3:0]       count;
    logic             proto_err;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_queue_if #(.WIDTH(WIDTH)) bus ();

    alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .acc_q     (acc_q),
        .count     (count),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] op, input logic rdy);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_op     = op;
        bus.out_ready = rdy;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset with in_valid held high
        rst_n = 1'b0;
        drive(1'b1, 8'h55, 3'd0, 1'b0);
        tick();
        tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_count",     32'(count),         32'd0);
        check("rst_acc",       32'(acc_q),         32'h00);
        check("rst_proto_err", 32'(proto_err),     32'd0);

        drive(1'b0, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // 2. Single pass: 00/op4
        drive(1'b1, 8'h00, 3'd4, 1'b1);
        tick();
        check("t2_out_valid", 32'(bus.out_valid), 32'd1);
        check("t2_out_data",  32'(bus.out_data),  32'h00);
        check("t2_out_op",    32'(bus.out_op),    32'd4);
        check("t2_flags",     32'(bus.out_flags), 32'({P_EN, 3'b001}));
        check("t2_count",     32'(count),         32'd1);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        tick();
        check("t2_acc",       32'(acc_q),         32'h00);
        check("t2_count_end", 32'(count),         32'd0);
        check("t2_empty",     32'(bus.out_valid), 32'd0);

        // 3. Fill to full
        drive(1'b1, 8'h80, 3'd7, 1'b0);
        tick();
        check("t3_count1", 32'(count), 32'd1);
        drive(1'b1, 8'h0F, 3'd5, 1'b0);
        tick();
        check("t3_count2",   32'(count),         32'd2);
        check("t3_in_ready", 32'(bus.in_ready),  32'd0);
        check("t3_head",     32'(bus.out_data),  32'h80);
        check("t3_flags",    32'(bus.out_flags), 32'b0110);
        drive(1'b1, 8'hAA, 3'd1, 1'b0);
        tick();
        check("t3_no_push",  32'(count),         32'd2);
        check("t3_head_hold",32'(bus.out_data),  32'h80);
        check("t3_no_err",   32'(proto_err),     32'd0);

        // 4. Full plus one pop; stalled AA held stable
        drive(1'b1, 8'hAA, 3'd1, 1'b1);
        tick();
        check("t4_acc",      32'(acc_q),         32'h80);
        check("t4_count",    32'(count),         32'd1);
        check("t4_in_ready", 32'(bus.in_ready),  32'd1);
        check("t4_head",     32'(bus.out_data),  32'h0F);
        check("t4_flags",    32'(bus.out_flags), 32'({P_EN, 3'b000}));
        drive(1'b1, 8'hAA, 3'd1, 1'b0);
        tick();
        check("t4_refill",   32'(count),         32'd2);
        check("t4_head2",    32'(bus.out_data),  32'h0F);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        tick();
        check("t4_acc2",     32'(acc_q),         32'h0F);
        check("t4_count2",   32'(count),         32'd1);
        check("t4_head3",    32'(bus.out_data),  32'hAA);
        check("t4_no_err",   32'(proto_err),     32'd0);

        // 5. Concurrent push+pop at count=1, incrementing data
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h10 + i), 3'(i), 1'b1);
            tick();
            check("t5_count", 32'(count), 32'd1);
            check("t5_acc",   32'(acc_q), (i == 0) ? 32'hAA : 32'(8'h10 + i - 1));
        end
        check("t5_head", 32'(bus.out_data), 32'h19);
        drive(1'b0, 8'h00, 3'd0, 1'b1);
        tick();
        check("t5_drain_acc",   32'(acc_q), 32'h19);
        check("t5_drain_count", 32'(count), 32'd0);
        tick();
        check("empty_pop_count", 32'(count),         32'd0);
        check("empty_pop_valid", 32'(bus.out_valid), 32'd0);
        check("empty_pop_acc",   32'(acc_q),         32'h19);

        // 6. Protocol violation, then reset mid-stream
        drive(1'b1, 8'h01, 3'd0, 1'b0);
        tick();
        drive(1'b1, 8'h02, 3'd0, 1'b0);
        tick();
        check("t6_full", 32'(count), 32'd2);
        drive(1'b1, 8'h03, 3'd0, 1'b0);
        tick();
        check("t6_stall_ok", 32'(proto_err), 32'd0);
        drive(1'b1, 8'h04, 3'd0, 1'b0);
        tick();
        check("t6_err_set", 32'(proto_err), 32'd1);
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        check("t6_err_sticky", 32'(proto_err), 32'd1);
        check("t6_count_kept", 32'(count),     32'd2);
        drive(1'b1, 8'h05, 3'd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_count",    32'(count),         32'd0);
        check("t6_rst_err",      32'(proto_err),     32'd0);
        check("t6_rst_valid",    32'(bus.out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(bus.in_ready),  32'd0);
        check("t6_rst_acc",      32'(acc_q),         32'h00);
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t6_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("t6_rel_count",    32'(count),        32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
